// File: rtl/riscv_instr_loader_if.sv
// Command/data stream from a leaf_interface user output port into the loader.
// A word transfers on any rising edge where vld_in && ack_out.
interface riscv_instr_loader_if;
  logic [31:0] din;
  logic        vld_in;
  logic        ack_out;

  modport master (output din, output vld_in, input  ack_out);
  modport slave  (input  din, input  vld_in, output ack_out);
endinterface

// File: rtl/riscv_instr_loader.sv
// Boot sequencer for the picorv32 instruction BRAM: parses LOAD/RUN/HALT headers,
// unpacks payload words into little-endian byte writes and owns the core's resetn.
module riscv_instr_loader #(
  parameter int ADDR_BITS = 24,
  parameter int CNT_BITS  = 16
) (
  input  logic                 clk_user,
  input  logic                 reset,
  input  logic                 ap_start,
  riscv_instr_loader_if.slave  cmd,
  output logic [ADDR_BITS-1:0] instr_config_addr,
  output logic [7:0]           instr_config_din,
  output logic                 instr_config_wr_en,
  output logic                 core_resetn,
  output logic                 busy,
  output logic                 loaded,
  output logic                 cmd_err
);
  typedef enum logic [1:0] {IDLE, COUNT, WAIT_WORD, BYTE} state_t;

  localparam logic [7:0] OP_LOAD = 8'h01;
  localparam logic [7:0] OP_RUN  = 8'h02;
  localparam logic [7:0] OP_HALT = 8'h03;

  state_t               state, state_nxt;
  logic                 ack_q, ack, xfer, run_flag;
  logic [ADDR_BITS-1:0] base, offset;
  logic [CNT_BITS-1:0]  remaining;
  logic [31:0]          word;
  logic [1:0]           byte_idx;

  // ack_q holds the post-reset value so the port reads 1 in the very first cycle after reset.
  assign ack         = ack_q & ~reset;
  assign cmd.ack_out = ack;
  assign xfer        = cmd.vld_in & ack;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (xfer && cmd.din[31:24] == OP_LOAD) state_nxt = COUNT;
      COUNT:     if (xfer) state_nxt = (cmd.din[CNT_BITS-1:0] == '0) ? IDLE : WAIT_WORD;
      WAIT_WORD: if (xfer) state_nxt = BYTE;
      BYTE:      if (byte_idx == 2'd3)
                   state_nxt = (remaining == CNT_BITS'(1)) ? IDLE : WAIT_WORD;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_user) begin
    if (reset) begin
      state              <= IDLE;
      ack_q              <= 1'b1;
      run_flag           <= 1'b0;
      base               <= '0;
      offset             <= '0;
      remaining          <= '0;
      word               <= '0;
      byte_idx           <= '0;
      instr_config_addr  <= '0;
      instr_config_din   <= '0;
      instr_config_wr_en <= 1'b0;
      core_resetn        <= 1'b0;
      busy               <= 1'b0;
      loaded             <= 1'b0;
      cmd_err            <= 1'b0;
    end else begin
      state              <= state_nxt;
      ack_q              <= (state_nxt != BYTE);
      busy               <= (state_nxt != IDLE);
      core_resetn        <= run_flag && ap_start && (state_nxt == IDLE);
      cmd_err            <= 1'b0;
      instr_config_wr_en <= 1'b0;
      case (state)
        IDLE: if (xfer) begin
          case (cmd.din[31:24])
            OP_LOAD: begin
              base     <= cmd.din[ADDR_BITS-1:0];
              offset   <= '0;
              run_flag <= 1'b0;
              loaded   <= 1'b0;
            end
            OP_RUN:  run_flag <= 1'b1;
            OP_HALT: run_flag <= 1'b0;
            default: cmd_err  <= 1'b1;
          endcase
        end
        COUNT: if (xfer) begin
          remaining <= cmd.din[CNT_BITS-1:0];
          if (cmd.din[CNT_BITS-1:0] == '0) loaded <= 1'b1;
        end
        // Byte 0 goes out on the acceptance edge so writes start the cycle after transfer.
        WAIT_WORD: if (xfer) begin
          word               <= cmd.din;
          byte_idx           <= 2'd0;
          instr_config_wr_en <= 1'b1;
          instr_config_addr  <= base + offset;
          instr_config_din   <= cmd.din[7:0];
          offset             <= offset + 1'b1;
        end
        BYTE: begin
          if (byte_idx == 2'd3) begin
            remaining <= remaining - 1'b1;
            if (remaining == CNT_BITS'(1)) loaded <= 1'b1;
          end else begin
            byte_idx           <= byte_idx + 2'd1;
            instr_config_wr_en <= 1'b1;
            instr_config_addr  <= base + offset;
            instr_config_din   <= word[{byte_idx + 2'd1, 3'b000} +: 8];
            offset             <= offset + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
